puf_resp_sender: RTL
====================

Name: puf_resp_sender

Overview:
- Parametrised response router and serialiser for the PUF readout path.
- Selects one of N_SRC response sources: raw PUF, ECC-corrected, SHA digest, or spare.
- Latches the selected word on its valid strobe, then streams it byte-by-byte to the UART transmitter using a DV/done handshake.
- Replaces the combinational source mux in front of the UART controller. Adds capture, busy, overrun reporting and an optional header byte.

Parameters:
- N_SRC, 4, number of response sources.
- SEL_W, 2, width of source select; indices >= N_SRC are disabled.
- RESP_W, 264, width of each source word; must be a multiple of 8; narrower sources are zero-extended by the instantiator.
- NBYTES, RESP_W/8, payload bytes per transfer (derived, not overridden).

Ports:
- clk  in  1  system clock (10 MHz domain).
- reset_n  in  1  asynchronous active-low reset.
- sel  in  SEL_W  source select, sampled only in IDLE.
- src_data  in  N_SRC*RESP_W  packed source words; source k at [k*RESP_W +: RESP_W].
- src_valid  in  N_SRC  one-cycle valid strobes, one per source.
- tx_done  in  1  one-cycle pulse from UART TX when a byte has finished.
- tx_byte  out  8  byte to transmit.
- tx_dv  out  1  one-cycle request to UART TX.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse after the last byte's tx_done.
- overrun  out  1  sticky; a selected-source strobe arrived while busy.

Behaviour:
- Reset: all outputs 0; shift register 0; byte counter 0; state IDLE. Asserting reset_n low mid-transfer aborts immediately. No further tx_dv is issued. A tx_done arriving after release is ignored in IDLE.
- States: IDLE, LOAD, SEND, WAIT, FIN.
- IDLE:
  - If sel < N_SRC and src_valid[sel]=1, capture src_data[sel] into the shift register and latch sel. Go to LOAD with busy=1 on the next edge.
  - If sel >= N_SRC, all strobes are ignored.
  - Strobes on non-selected sources are always ignored.
- LOAD: load byte counter = NBYTES-1, plus header count if enabled. Go to SEND.
- SEND: drive tx_byte = the current most-significant byte of the shift register, MSB-first byte order. Pulse tx_dv for exactly one cycle. Go to WAIT.
- WAIT:
  - On tx_done, shift the register left by 8.
  - If counter == 0, go to FIN; else decrement the counter and go to SEND.
  - tx_done in any other state is ignored.
- FIN: pulse done for one cycle, clear busy, return to IDLE.
- Next capture is possible the cycle after done.
- tx_byte holds its value from SEND until the next SEND; it is not cleared after a transfer.
- Latency: capture strobe to first tx_dv = 2 clocks. Minimum tx_done to next tx_dv = 1 clock.
- Changes to sel or src_data while busy do not affect the transfer in flight.
- Overrun: src_valid[latched sel] high in any state other than IDLE sets overrun=1. It stays high until reset. The strobe is dropped and the transfer continues.
- Simultaneous: strobe in the same cycle as FIN is an overrun, not a capture.
- No timeout: WAIT holds indefinitely until tx_done or reset.

Optional Feature:
- Macro: PUF_RESP_SENDER_HDR_EN.
- Defined: one header byte 8'hA0 | {latched sel, zero-extended to 4 bits} is sent before the payload. Total bytes = NBYTES+1. The header uses the same SEND/WAIT handshake.
- Undefined: payload only, NBYTES bytes. No header logic is synthesised.

Test Plan:
- RESP_W=16, sel=1, src_data[1]=16'hBEEF, pulse src_valid[1]; TX model returns tx_done 5 cycles after each tx_dv -> tx_byte 8'hBE then 8'hEF, exactly 2 tx_dv pulses, first tx_dv 2 clocks after the strobe, done pulse once, busy low after done.
- sel=3 with N_SRC=3, pulse src_valid[0..2] -> no tx_dv, busy stays 0.
- During the second byte of a transfer, pulse src_valid[latched sel] and change sel to 0 -> overrun=1 (sticky), bytes still from the original capture, no second transfer.
- Drive reset_n low for 1 cycle while in WAIT, then issue a stray tx_done -> outputs 0, state IDLE, no tx_dv; a new strobe then transfers normally.
- With PUF_RESP_SENDER_HDR_EN, sel=2, RESP_W=16, data 16'h1234 -> bytes 8'hA2, 8'h12, 8'h34; done after the third tx_done.
- Default RESP_W=264, all-ones data -> 33 tx_dv pulses of 8'hFF, counter wraps cleanly, done once.

Source files
------------

// File: rtl/puf_resp_sender.sv
// puf_resp_sender: response router and byte serialiser for the PUF readout path.
// Captures the word of the selected source on its valid strobe and streams it
// MSB-byte-first to the UART transmitter over a tx_dv / tx_done handshake.
// Optional build macro PUF_RESP_SENDER_HDR_EN: prepend a header byte
// {4'hA, latched sel} ahead of the payload.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a strobe on the selected source
// LOAD   | load byte counter for the transfer
// SEND   | tx_dv high for one cycle, tx_byte holds current byte
// WAIT   | waiting for tx_done; then next byte or finish
// FIN    | done pulse, busy dropped on exit
module puf_resp_sender #(
   parameter int N_SRC  = 4,
   parameter int SEL_W  = 2,
   parameter int RESP_W = 264
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [SEL_W-1:0]        sel,
   input  logic [N_SRC*RESP_W-1:0] src_data,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic                    tx_done,
   output logic [7:0]              tx_byte,
   output logic                    tx_dv,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   localparam int NBYTES = RESP_W / 8;
`ifdef PUF_RESP_SENDER_HDR_EN
   localparam int HDR_N  = 1;
`else
   localparam int HDR_N  = 0;
`endif
   localparam int SH_W   = RESP_W + 8 * HDR_N;
   localparam int TOT_B  = NBYTES + HDR_N;
   localparam int CNT_W  = (TOT_B > 1) ? $clog2(TOT_B) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_FIN} state_t;

   state_t            r_state;
   logic [SH_W-1:0]   r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic [SEL_W-1:0]  r_sel;
   logic [7:0]        r_tx_byte;
   logic              r_tx_dv;
   logic              r_busy;
   logic              r_done;
   logic              r_overrun;

   logic              w_cap_valid;
   logic [RESP_W-1:0] w_cap_data;
   logic              w_lat_valid;
   logic [SH_W-1:0]   w_load;
   logic [SH_W-1:0]   w_shift_nxt;

   // Source muxes: live sel for capture, latched sel for overrun detection.
   // A sel value with no matching source leaves w_cap_valid low.
   always_comb begin
      w_cap_valid = 1'b0;
      w_cap_data  = '0;
      w_lat_valid = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            w_cap_valid = src_valid[k];
            w_cap_data  = src_data[k*RESP_W +: RESP_W];
         end
         if (r_sel == SEL_W'(k)) begin
            w_lat_valid = src_valid[k];
         end
      end
      w_shift_nxt = r_shift << 8;
   end

`ifdef PUF_RESP_SENDER_HDR_EN
   assign w_load = {4'hA, 4'(sel), w_cap_data};
`else
   assign w_load = w_cap_data;
`endif

   // Transfer sequencer with registered handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_sel     <= '0;
         r_tx_byte <= 8'h00;
         r_tx_dv   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cap_valid) begin
                  r_shift <= w_load;
                  r_sel   <= sel;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_cnt     <= CNT_W'(TOT_B - 1);
               r_tx_byte <= r_shift[SH_W-1 -: 8];
               r_tx_dv   <= 1'b1;
               r_state   <= S_SEND;
            end
            S_SEND: begin
               r_tx_dv <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_done) begin
                  r_shift <= w_shift_nxt;
                  if (r_cnt == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_cnt     <= r_cnt - CNT_W'(1);
                     r_tx_byte <= w_shift_nxt[SH_W-1 -: 8];
                     r_tx_dv   <= 1'b1;
                     r_state   <= S_SEND;
                  end
               end
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_tx_dv <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun: a strobe on the latched source while a transfer is in
   // flight (FIN included) is dropped and flagged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun <= 1'b0;
      end else if (r_state != S_IDLE && w_lat_valid) begin
         r_overrun <= 1'b1;
      end
   end

   assign tx_byte = r_tx_byte;
   assign tx_dv   = r_tx_dv;
   assign busy    = r_busy;
   assign done    = r_done;
   assign overrun = r_overrun;

endmodule
